uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
Receive-side companion to uart_tx. It consumes an asynchronous 8N1 serial line: 1 start bit, 8 data bits LSB first, 1 stop bit, idle high. It recovers each byte by mid-bit sampling and presents it on a valid/ready byte interface, held in a one-entry holding register. It flags framing errors and overruns with single-cycle pulses.

Parameters:
CLK_RATE, 50_000_000, system clock frequency in Hz.
BAUD_RATE, 115200, line bit rate.
- Derived: CLKS_PER_BAUD = CLK_RATE / BAUD_RATE, integer division.
- CLKS_PER_BAUD >= 4 is required; otherwise elaboration fails with an error.

Ports:
clk  input  1  system clock; all logic on its rising edge.
reset  input  1  synchronous, active-high reset.
rx  input  1  serial line; asynchronous to clk; idles high.
data  output  8  received byte; stable while valid=1.
valid  output  1  holding register contains an unconsumed byte.
ready  input  1  consumer accepts data on a cycle where valid=1 and ready=1.
frame_err  output  1  one-cycle pulse: stop bit sampled low.
overrun  output  1  one-cycle pulse: a good byte arrived while the holding register was full; the new byte is dropped.

Behaviour:
- Reset state:
  - data=0, valid=0, frame_err=0, overrun=0.
  - Both synchronizer flops = 1; FSM = IDLE.
  - Reset mid-frame discards the partial byte.
- Input synchronization: rx passes through a 2-flop synchronizer; rx_s is the second stage. All decisions use rx_s only.
- Counters: clk_cnt is 32 bits, counts down. bit_cnt is 4 bits.
- FSM states: IDLE, START, DATA, STOP, BREAK.
- IDLE:
  - When rx_s=0: go to START and load clk_cnt = CLKS_PER_BAUD/2 - 1.
- START:
  - Decrement clk_cnt each cycle.
  - At clk_cnt=0 with rx_s=0: go to DATA, load clk_cnt = CLKS_PER_BAUD - 1, set bit_cnt = 0.
  - At clk_cnt=0 with rx_s=1: glitch; return to IDLE, no outputs.
- DATA:
  - Decrement clk_cnt each cycle.
  - At clk_cnt=0: shift rx_s into the MSB of an 8-bit shift register (right shift), increment bit_cnt, reload clk_cnt = CLKS_PER_BAUD - 1.
  - After the 8th sample (bit_cnt reaches 8): go to STOP.
- STOP:
  - At clk_cnt=0 with rx_s=1: byte delivery event, then go to IDLE. The start edge of the next frame is detectable from the following cycle, so zero-gap back-to-back frames are received.
  - At clk_cnt=0 with rx_s=0: frame_err=1 for exactly one cycle, byte discarded, go to BREAK.
- BREAK: stay until rx_s=1, then go to IDLE. A held-low line produces exactly one frame_err.
- Delivery event, evaluated on the same clock edge:
  - valid=0: load data, valid←1.
  - valid=1 and ready=1: the old byte is consumed and the new byte loaded; valid stays 1; no overrun.
  - valid=1 and ready=0: data unchanged; overrun=1 for one cycle.
- Consumption without delivery: valid=1 and ready=1 clears valid on the next edge. data keeps its last value.
- Latency: valid rises on the edge where STOP samples rx_s=1. That edge is the middle of the stop bit, plus 2 synchronizer cycles relative to rx.
- ready has no effect while valid=0. frame_err and overrun are never asserted in the same cycle.
- Tolerance: sampling at bit centres tolerates about ±4% baud mismatch at CLKS_PER_BAUD >= 16.

Test Plan:
Common setup: CLK_RATE=1_600_000, BAUD_RATE=100_000, so CLKS_PER_BAUD=16.
1. Send 0xA5 with ready=1 -> valid high for exactly 1 cycle, data=0xA5, frame_err=0, overrun=0; valid rises 2 + 8 + 9*16 (±1) cycles after the rx falling edge.
2. Drive rx low for 4 cycles, then high; then send 0x3C -> no valid or frame_err for the glitch; 0x3C received correctly.
3. Send 0x55 with the stop bit low, hold rx low for 40 cycles, release; then send 0x81 -> one frame_err pulse, no valid for 0x55; 0x81 received.
4. With ready=0, send 0x11 then 0x22 -> valid=1, data=0x11; one overrun pulse at the 0x22 stop sample. Then ready=1 for 1 cycle -> valid=0 and data still 0x11.
5. Send 0x00 and 0xFF back-to-back with no idle gap, ready=1; then repeat at a line bit period of 17 clocks -> both bytes received in both cases, no flags.
6. Assert reset for 1 cycle after the 4th data bit of 0xF0, then send 0x5A -> no valid for the aborted frame; 0x5A received with no flags.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling behind a 2-flop synchronizer; valid rises 2 + CLKS/2 + 9*CLKS cycles after the start edge.
// One-entry holding register with valid/ready; a good byte arriving while it is full and not being drained is dropped (overrun pulse).
`timescale 1ns/1ps
module uart_rx #(
    parameter int unsigned CLK_RATE  = 50_000_000,
    parameter int unsigned BAUD_RATE = 115200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       frame_err,
    output logic       overrun
);

    localparam int unsigned CLKS_PER_BAUD = CLK_RATE / BAUD_RATE;
    localparam logic [31:0] FULL_LOAD     = 32'(CLKS_PER_BAUD - 1);
    localparam logic [31:0] HALF_LOAD     = 32'(CLKS_PER_BAUD / 2 - 1);

    generate
        if (CLKS_PER_BAUD < 4) begin : g_bad_rate
            $error("uart_rx: CLK_RATE/BAUD_RATE must be at least 4");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_sync1;
    logic        r_sync2;
    logic        w_rx_s;
    logic [31:0] r_clk_cnt;
    logic [31:0] w_clk_cnt_nxt;
    logic [3:0]  r_bit_cnt;
    logic [3:0]  w_bit_cnt_nxt;
    logic [7:0]  r_shift;
    logic [7:0]  w_shift_nxt;
    logic        w_cnt_zero;
    logic        w_deliver;
    logic        w_ferr;
    logic [7:0]  r_data;
    logic        r_valid;
    logic        r_frame_err;
    logic        r_overrun;

    assign w_rx_s     = r_sync2;
    assign w_cnt_zero = (r_clk_cnt == 32'd0);

    always_comb begin
        w_state_nxt   = r_state;
        w_clk_cnt_nxt = r_clk_cnt;
        w_bit_cnt_nxt = r_bit_cnt;
        w_shift_nxt   = r_shift;
        w_deliver     = 1'b0;
        w_ferr        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_rx_s) begin
                    w_state_nxt   = S_START;
                    w_clk_cnt_nxt = HALF_LOAD;
                end
            end
            S_START: begin
                if (w_cnt_zero) begin
                    // Start bit must still be low at its centre, else it was a glitch.
                    if (!w_rx_s) begin
                        w_state_nxt   = S_DATA;
                        w_clk_cnt_nxt = FULL_LOAD;
                        w_bit_cnt_nxt = 4'd0;
                    end else begin
                        w_state_nxt   = S_IDLE;
                    end
                end else begin
                    w_clk_cnt_nxt = r_clk_cnt - 32'd1;
                end
            end
            S_DATA: begin
                if (w_cnt_zero) begin
                    w_shift_nxt   = {w_rx_s, r_shift[7:1]};
                    w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                    w_clk_cnt_nxt = FULL_LOAD;
                    if (w_bit_cnt_nxt == 4'd8) begin
                        w_state_nxt = S_STOP;
                    end
                end else begin
                    w_clk_cnt_nxt = r_clk_cnt - 32'd1;
                end
            end
            S_STOP: begin
                if (w_cnt_zero) begin
                    if (w_rx_s) begin
                        w_deliver   = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_ferr      = 1'b1;
                        w_state_nxt = S_BREAK;
                    end
                end else begin
                    w_clk_cnt_nxt = r_clk_cnt - 32'd1;
                end
            end
            S_BREAK: begin
                if (w_rx_s) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_sync1     <= 1'b1;
            r_sync2     <= 1'b1;
            r_clk_cnt   <= 32'd0;
            r_bit_cnt   <= 4'd0;
            r_shift     <= 8'd0;
            r_data      <= 8'd0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_sync1     <= rx;
            r_sync2     <= r_sync1;
            r_state     <= w_state_nxt;
            r_clk_cnt   <= w_clk_cnt_nxt;
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_shift     <= w_shift_nxt;
            r_frame_err <= w_ferr;
            r_overrun   <= w_deliver && r_valid && !ready;
            // A same-cycle drain frees the slot, so the new byte replaces the old one.
            if (w_deliver && (!r_valid || ready)) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
            end else if (r_valid && ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign data      = r_data;
    assign valid     = r_valid;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: 16-clock bit period on the main instance, plus a 17-clock-divisor instance.
`timescale 1ns/1ps
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx;
    logic       ready;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       overrun;
    logic       rx2;
    logic       ready2;
    logic [7:0] data2;
    logic       valid2;
    logic       frame_err2;
    logic       overrun2;

    always #5 clk = ~clk;

    uart_rx #(.CLK_RATE(1_600_000), .BAUD_RATE(100_000)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .data      (data),
        .valid     (valid),
        .ready     (ready),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    uart_rx #(.CLK_RATE(1_700_000), .BAUD_RATE(100_000)) u_dut17 (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx2),
        .data      (data2),
        .valid     (valid2),
        .ready     (ready2),
        .frame_err (frame_err2),
        .overrun   (overrun2)
    );

    int total = 0;
    int bad   = 0;

    int         cyc = 0;
    int         t_fall = 0;
    int         first_v = -1;
    int         n_vcyc = 0;
    int         n_ferr = 0;
    int         n_ovr = 0;
    int         n_both = 0;
    int         n_ferr2 = 0;
    int         n_ovr2 = 0;
    logic [7:0] q[$];
    logic [7:0] q2[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid && ready) q.push_back(data);
        if (valid) begin
            n_vcyc++;
            if (first_v < 0) first_v = cyc;
        end
        if (frame_err) n_ferr++;
        if (overrun) n_ovr++;
        if (frame_err && overrun) n_both++;
        if (frame_err2 && overrun2) n_both++;
        if (valid2 && ready2) q2.push_back(data2);
        if (frame_err2) n_ferr2++;
        if (overrun2) n_ovr2++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] qat(input bit sel, input int i);
        if (sel) return (i < q2.size()) ? {24'd0, q2[i]} : 32'hDEAD;
        return (i < q.size()) ? {24'd0, q[i]} : 32'hDEAD;
    endfunction

    task automatic clear();
        q.delete();
        q2.delete();
        first_v = -1;
        n_vcyc  = 0;
        n_ferr  = 0;
        n_ovr   = 0;
        n_ferr2 = 0;
        n_ovr2  = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; each bit is held for 'per' clocks, LSB first.
    task automatic send(input logic [7:0] b, input int per, input bit stop_bit, input bit line2);
        logic [9:0] fr;
        fr = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            if (line2) rx2 = fr[i];
            else       rx  = fr[i];
            if (i == 0) t_fall = cyc;
            idle(per);
        end
    endtask

    initial begin
        int lat;
        reset  = 1'b1;
        rx     = 1'b1;
        rx2    = 1'b1;
        ready  = 1'b0;
        ready2 = 1'b1;
        idle(3);
        chk("rst_data", {24'd0, data}, 32'h00);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_ferr", {31'd0, frame_err}, 32'd0);
        chk("rst_ovr", {31'd0, overrun}, 32'd0);
        reset = 1'b0;
        idle(5);

        // 1: single byte, ready held high
        ready = 1'b1;
        clear();
        send(8'hA5, 16, 1'b1, 1'b0);
        idle(20);
        lat = first_v - t_fall - 1;
        chk("t1_count", q.size(), 32'd1);
        chk("t1_byte", qat(0, 0), 32'hA5);
        chk("t1_vwidth", n_vcyc, 32'd1);
        chk("t1_latency_ok", {31'd0, (lat >= 153 && lat <= 155)}, 32'd1);
        chk("t1_ferr", n_ferr, 32'd0);
        chk("t1_ovr", n_ovr, 32'd0);

        // 2: 4-cycle glitch, then a real byte
        clear();
        rx = 1'b0;
        idle(4);
        rx = 1'b1;
        idle(30);
        chk("t2_glitch_valid", n_vcyc, 32'd0);
        chk("t2_glitch_ferr", n_ferr, 32'd0);
        send(8'h3C, 16, 1'b1, 1'b0);
        idle(20);
        chk("t2_count", q.size(), 32'd1);
        chk("t2_byte", qat(0, 0), 32'h3C);
        chk("t2_ferr", n_ferr, 32'd0);

        // 3: bad stop bit, line held low (break), then recovery
        clear();
        send(8'h55, 16, 1'b0, 1'b0);
        idle(40);
        rx = 1'b1;
        idle(20);
        chk("t3_break_valid", n_vcyc, 32'd0);
        send(8'h81, 16, 1'b1, 1'b0);
        idle(20);
        chk("t3_ferr", n_ferr, 32'd1);
        chk("t3_count", q.size(), 32'd1);
        chk("t3_byte", qat(0, 0), 32'h81);
        chk("t3_ovr", n_ovr, 32'd0);

        // 4: overrun with the holding register full
        ready = 1'b0;
        clear();
        send(8'h11, 16, 1'b1, 1'b0);
        idle(20);
        chk("t4_valid_first", {31'd0, valid}, 32'd1);
        chk("t4_data_first", {24'd0, data}, 32'h11);
        send(8'h22, 16, 1'b1, 1'b0);
        idle(20);
        chk("t4_ovr", n_ovr, 32'd1);
        chk("t4_valid_held", {31'd0, valid}, 32'd1);
        chk("t4_data_held", {24'd0, data}, 32'h11);
        chk("t4_ferr", n_ferr, 32'd0);
        ready = 1'b1;
        idle(1);
        ready = 1'b0;
        idle(2);
        chk("t4_valid_drained", {31'd0, valid}, 32'd0);
        chk("t4_data_kept", {24'd0, data}, 32'h11);
        chk("t4_popped", qat(0, 0), 32'h11);

        // 5: back-to-back frames at 16 clocks/bit, then on the 17-clock instance
        ready = 1'b1;
        clear();
        send(8'h00, 16, 1'b1, 1'b0);
        send(8'hFF, 16, 1'b1, 1'b0);
        idle(20);
        chk("t5_count", q.size(), 32'd2);
        chk("t5_byte0", qat(0, 0), 32'h00);
        chk("t5_byte1", qat(0, 1), 32'hFF);
        chk("t5_flags", n_ferr + n_ovr, 32'd0);
        send(8'h00, 17, 1'b1, 1'b1);
        send(8'hFF, 17, 1'b1, 1'b1);
        idle(20);
        chk("t5_17_count", q2.size(), 32'd2);
        chk("t5_17_byte0", qat(1, 0), 32'h00);
        chk("t5_17_byte1", qat(1, 1), 32'hFF);
        chk("t5_17_flags", n_ferr2 + n_ovr2, 32'd0);

        // 6: reset after the 4th data bit of 0xF0 (remaining bits and stop are all high)
        clear();
        rx = 1'b0;
        idle(5 * 16);
        rx    = 1'b1;
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        chk("t6_rst_valid", {31'd0, valid}, 32'd0);
        chk("t6_rst_data", {24'd0, data}, 32'h00);
        idle(5 * 16 + 20);
        chk("t6_abort_valid", n_vcyc, 32'd0);
        send(8'h5A, 16, 1'b1, 1'b0);
        idle(20);
        chk("t6_count", q.size(), 32'd1);
        chk("t6_byte", qat(0, 0), 32'h5A);
        chk("t6_flags", n_ferr + n_ovr, 32'd0);

        chk("never_both_flags", n_both, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
